// File: rtl/edge_to_level.sv
// -----------------------------------------------------------------------------
// edge_to_level
//
// Regenerates a clean level waveform from single-cycle Edge strobes. An
// accepted strobe produces HIGH_CYCLES of Level=1, then GAP_CYCLES of
// guaranteed low before another strobe can be taken. Alongside that it counts
// accepted edges, flags dropped edges (Overrun), and flags a long silence
// (Timeout). Everything is held idle unless DigitSupply reads 2'b10.
//
// Optional build macro: EDGE_TO_LEVEL_RETRIGGER_EN
//   defined   - strobes in HIGH restart the high phase, strobes in GAP jump
//               straight back to HIGH; nothing is ever dropped, so Overrun
//               stays 0 (the port is kept for a stable interface).
//   undefined - strobes in HIGH or GAP are dropped and set Overrun.
//
// Ports:
//   Clock         in   system clock, rising edge
//   nReset        in   asynchronous active-low reset
//   DigitSupply   in   [1:0] rail pair; block enabled only at 2'b10
//   Edge          in   single-cycle strobe, synchronous to Clock
//   ClearOverrun  in   synchronous clear of Overrun (a same-cycle set wins)
//   Level         out  regenerated level, registered
//   Busy          out  high while in HIGH or GAP
//   Overrun       out  sticky: an edge was dropped
//   Timeout       out  no accepted edge for TIMEOUT_CYCLES enabled idle cycles
//   EdgeCount     out  [CNT_W-1:0] accepted edges, wraps silently
// -----------------------------------------------------------------------------
module edge_to_level #(
   parameter int HIGH_CYCLES    = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic [1:0]       DigitSupply,
   input  logic             Edge,
   input  logic             ClearOverrun,
   output logic             Level,
   output logic             Busy,
   output logic             Overrun,
   output logic             Timeout,
   output logic [CNT_W-1:0] EdgeCount
);

   // Phase counter runs 0..N-1 inside HIGH or GAP, so it only needs to hold
   // the larger of the two lengths minus one.
   localparam int PH_MAX = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
   localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam logic [PW-1:0] HIGH_LAST = PW'(HIGH_CYCLES - 1);
   // GAP_LAST is never used when GAP_CYCLES==0 (HIGH goes straight to IDLE).
   localparam logic [PW-1:0] GAP_LAST  = PW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   // Timeout counter saturates at TIMEOUT_CYCLES.
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    ph_q, ph_d;
   logic [TW-1:0]    to_q, to_d;
   logic             level_q, level_d;
   logic             busy_q, busy_d;
   logic             ovr_q, ovr_d;
   logic             tflag_q, tflag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             en;
   logic             accept;
`ifndef EDGE_TO_LEVEL_RETRIGGER_EN
   logic             drop;
`endif

   assign en = (DigitSupply == 2'b10);

   // --------------------------------------------------------------------------
   // State register (all flops, including registered outputs)
   // --------------------------------------------------------------------------
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= S_IDLE;
         ph_q    <= '0;
         to_q    <= '0;
         level_q <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
         tflag_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         to_q    <= to_d;
         level_q <= level_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
         tflag_q <= tflag_d;
         cnt_q   <= cnt_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      accept  = 1'b0;
`ifndef EDGE_TO_LEVEL_RETRIGGER_EN
      drop    = 1'b0;
`endif
      if (!en) begin
         // Supply not valid: abandon any phase, ignore strobes.
         state_d = S_IDLE;
         ph_d    = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (Edge) begin
                  accept  = 1'b1;
                  state_d = S_HIGH;
                  ph_d    = '0;
               end
            end
            S_HIGH: begin
               if (ph_q == HIGH_LAST) begin
                  ph_d    = '0;
                  state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
               end else begin
                  ph_d = ph_q + PW'(1);
               end
`ifdef EDGE_TO_LEVEL_RETRIGGER_EN
               // Restart the high phase from its first cycle.
               if (Edge) begin
                  accept  = 1'b1;
                  state_d = S_HIGH;
                  ph_d    = '0;
               end
`else
               drop = Edge;
`endif
            end
            S_GAP: begin
               if (ph_q == GAP_LAST) begin
                  ph_d    = '0;
                  state_d = S_IDLE;
               end else begin
                  ph_d = ph_q + PW'(1);
               end
`ifdef EDGE_TO_LEVEL_RETRIGGER_EN
               if (Edge) begin
                  accept  = 1'b1;
                  state_d = S_HIGH;
                  ph_d    = '0;
               end
`else
               drop = Edge;
`endif
            end
            default: begin
               state_d = S_IDLE;
               ph_d    = '0;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Output / status logic (values registered by the state register above)
   // --------------------------------------------------------------------------
   always_comb begin
      // Level and Busy are decoded from the next state so they come straight
      // out of flops with no combinational path after the clock edge.
      level_d = (state_d == S_HIGH);
      busy_d  = (state_d != S_IDLE);

      cnt_d = accept ? (cnt_q + CNT_W'(1)) : cnt_q;

`ifdef EDGE_TO_LEVEL_RETRIGGER_EN
      // No set source exists in this build; the flop stays at its reset 0.
      ovr_d = ovr_q & ~ClearOverrun;
`else
      // A drop in the same cycle as ClearOverrun keeps the flag set.
      if (drop)
         ovr_d = 1'b1;
      else if (ClearOverrun)
         ovr_d = 1'b0;
      else
         ovr_d = ovr_q;
`endif

      // Counts enabled idle cycles without a strobe; frozen in HIGH/GAP.
      if (!en || accept)
         to_d = '0;
      else if (state_q == S_IDLE && to_q != TO_MAX)
         to_d = to_q + TW'(1);
      else
         to_d = to_q;

      // Flag follows the counter value it is being loaded with, so it rises
      // in the cycle right after the last qualifying idle cycle.
      tflag_d = en && (to_d == TO_MAX);
   end

   assign Level     = level_q;
   assign Busy      = busy_q;
   assign Overrun   = ovr_q;
   assign Timeout   = tflag_q;
   assign EdgeCount = cnt_q;

endmodule

// File: tb/tb_edge_to_level.sv
// -----------------------------------------------------------------------------
// tb_edge_to_level
//
// Self-checking bench for edge_to_level with default parameters. Each accepted
// strobe pushes its expected Level/Busy waveform (HIGH_CYCLES high+busy, then
// GAP_CYCLES low+busy) onto a scoreboard queue; every cycle one entry is popped
// and compared, an empty queue meaning "idle" (Level=0, Busy=0). Inputs are
// driven and outputs sampled on the falling edge; "cycle c" outputs reflect
// the rising edge that closed cycle c-1.
// -----------------------------------------------------------------------------
module tb_edge_to_level;

   localparam int HI = 4;
   localparam int GP = 2;
   localparam int TO = 64;
   localparam int CW = 8;

   logic          Clock = 1'b0;
   logic          nReset;
   logic [1:0]    DigitSupply;
   logic          Edge;
   logic          ClearOverrun;
   logic          Level;
   logic          Busy;
   logic          Overrun;
   logic          Timeout;
   logic [CW-1:0] EdgeCount;

   typedef struct packed {
      logic lvl;
      logic bsy;
   } exp_t;

   exp_t          sbq[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [CW-1:0] exp_cnt;

   always #5 Clock = ~Clock;

   edge_to_level #(
      .HIGH_CYCLES   (HI),
      .GAP_CYCLES    (GP),
      .TIMEOUT_CYCLES(TO),
      .CNT_W         (CW)
   ) dut (
      .Clock       (Clock),
      .nReset      (nReset),
      .DigitSupply (DigitSupply),
      .Edge        (Edge),
      .ClearOverrun(ClearOverrun),
      .Level       (Level),
      .Busy        (Busy),
      .Overrun     (Overrun),
      .Timeout     (Timeout),
      .EdgeCount   (EdgeCount)
   );

   // Expected waveform of one accepted strobe, starting the cycle after it.
   function automatic void push_pulse();
      exp_t e;
      for (int i = 0; i < HI; i++) begin
         e.lvl = 1'b1; e.bsy = 1'b1;
         sbq.push_back(e);
      end
      for (int i = 0; i < GP; i++) begin
         e.lvl = 1'b0; e.bsy = 1'b1;
         sbq.push_back(e);
      end
   endfunction

   task automatic test_reset();
      nReset = 1'b0; DigitSupply = 2'b10; Edge = 1'b1; ClearOverrun = 1'b0;
      repeat (3) @(negedge Clock);
      n_tests++;
      if ({Level, Busy, Overrun, Timeout} !== 4'b0000 || EdgeCount !== '0) begin
         n_fail++;
         $display("FAIL reset_hold got L%b B%b O%b T%b cnt=%0d, want all 0",
                  Level, Busy, Overrun, Timeout, EdgeCount);
      end
      Edge = 1'b0; nReset = 1'b1;
      sbq.delete(); exp_cnt = '0;
      @(negedge Clock);
      n_tests++;
      if ({Level, Busy, Overrun, Timeout} !== 4'b0000 || EdgeCount !== '0) begin
         n_fail++;
         $display("FAIL reset_release got L%b B%b O%b T%b cnt=%0d, want all 0",
                  Level, Busy, Overrun, Timeout, EdgeCount);
      end
   endtask

   task automatic test_single();
      exp_t e;
      for (int c = 0; c < 20; c++) begin
         @(negedge Clock);
         if (sbq.size() > 0) e = sbq.pop_front(); else e = '0;
         n_tests++;
         if ({Level, Busy} !== {e.lvl, e.bsy}) begin
            n_fail++;
            $display("FAIL single_wave c=%0d got L%b B%b want L%b B%b", c, Level, Busy, e.lvl, e.bsy);
         end
         Edge = (c == 10);
         if (c == 10) begin push_pulse(); exp_cnt++; end
      end
      Edge = 1'b0;
      n_tests++;
      if (EdgeCount !== exp_cnt || Overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL single_count got cnt=%0d O%b want cnt=%0d O0", EdgeCount, Overrun, exp_cnt);
      end
   endtask

`ifndef EDGE_TO_LEVEL_RETRIGGER_EN
   task automatic test_overrun();
      exp_t e;
      logic eo;
      // Second strobe lands in HIGH and must be dropped.
      for (int c = 0; c < 20; c++) begin
         @(negedge Clock);
         if (sbq.size() > 0) e = sbq.pop_front(); else e = '0;
         eo = (c >= 4);
         n_tests++;
         if ({Level, Busy, Overrun} !== {e.lvl, e.bsy, eo}) begin
            n_fail++;
            $display("FAIL overrun_set c=%0d got L%b B%b O%b want L%b B%b O%b",
                     c, Level, Busy, Overrun, e.lvl, e.bsy, eo);
         end
         Edge = (c == 0) || (c == 3);
         if (c == 0) begin push_pulse(); exp_cnt++; end
      end
      Edge = 1'b0;
      n_tests++;
      if (EdgeCount !== exp_cnt) begin
         n_fail++;
         $display("FAIL overrun_count got %0d want %0d", EdgeCount, exp_cnt);
      end
      // Drop in the last GAP cycle coinciding with ClearOverrun: set wins.
      // A lone ClearOverrun later clears it.
      for (int c = 0; c < 16; c++) begin
         @(negedge Clock);
         if (sbq.size() > 0) e = sbq.pop_front(); else e = '0;
         eo = (c <= 10);
         n_tests++;
         if ({Level, Busy, Overrun} !== {e.lvl, e.bsy, eo}) begin
            n_fail++;
            $display("FAIL overrun_clear c=%0d got L%b B%b O%b want L%b B%b O%b",
                     c, Level, Busy, Overrun, e.lvl, e.bsy, eo);
         end
         Edge         = (c == 0) || (c == 6);
         ClearOverrun = (c == 6) || (c == 10);
         if (c == 0) begin push_pulse(); exp_cnt++; end
      end
      Edge = 1'b0; ClearOverrun = 1'b0;
      n_tests++;
      if (EdgeCount !== exp_cnt) begin
         n_fail++;
         $display("FAIL overrun_count2 got %0d want %0d", EdgeCount, exp_cnt);
      end
   endtask
`else
   task automatic test_retrigger();
      exp_t e;
      // 0/2: retrigger inside HIGH; 20/25: retrigger in first GAP cycle.
      for (int c = 0; c < 35; c++) begin
         @(negedge Clock);
         if (sbq.size() > 0) e = sbq.pop_front(); else e = '0;
         n_tests++;
         if ({Level, Busy, Overrun} !== {e.lvl, e.bsy, 1'b0}) begin
            n_fail++;
            $display("FAIL retrig_wave c=%0d got L%b B%b O%b want L%b B%b O0",
                     c, Level, Busy, Overrun, e.lvl, e.bsy);
         end
         Edge = (c == 0) || (c == 2) || (c == 20) || (c == 25);
         if (Edge) begin sbq.delete(); push_pulse(); exp_cnt++; end
      end
      Edge = 1'b0;
      n_tests++;
      if (EdgeCount !== exp_cnt) begin
         n_fail++;
         $display("FAIL retrig_count got %0d want %0d", EdgeCount, exp_cnt);
      end
   endtask
`endif

   task automatic test_back_to_back();
      exp_t e;
      @(negedge Clock);
      nReset = 1'b0;
      @(negedge Clock);
      nReset = 1'b1;
      sbq.delete(); exp_cnt = '0;
      // Minimum period HI+GP+1 = 7; 300 strobes wrap the 8-bit count to 44.
      for (int c = 0; c < 300 * 7 + 8; c++) begin
         @(negedge Clock);
         if (sbq.size() > 0) e = sbq.pop_front(); else e = '0;
         n_tests++;
         if ({Level, Busy, Overrun} !== {e.lvl, e.bsy, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_wave c=%0d got L%b B%b O%b want L%b B%b O0",
                     c, Level, Busy, Overrun, e.lvl, e.bsy);
         end
         Edge = (c < 300 * 7) && (c % 7 == 0);
         if (Edge) begin push_pulse(); exp_cnt++; end
      end
      Edge = 1'b0;
      n_tests++;
      if (EdgeCount !== 8'd44 || exp_cnt !== 8'd44) begin
         n_fail++;
         $display("FAIL b2b_wrap got %0d want 44", EdgeCount);
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      logic et;
      @(negedge Clock);
      nReset = 1'b0;
      @(negedge Clock);
      nReset = 1'b1;
      sbq.delete(); exp_cnt = '0;
      for (int k = 1; k <= 70; k++) begin
         @(negedge Clock);
         et = (k >= TO);
         n_tests++;
         if (Timeout !== et) begin
            n_fail++;
            $display("FAIL timeout_rise k=%0d got %b want %b", k, Timeout, et);
         end
      end
      // Losing the supply clears the flag and the count.
      DigitSupply = 2'b01;
      @(negedge Clock);
      n_tests++;
      if (Timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_disable got %b want 0", Timeout);
      end
      DigitSupply = 2'b10;
      for (int k = 1; k <= 70; k++) begin
         @(negedge Clock);
         et = (k >= TO);
         n_tests++;
         if (Timeout !== et) begin
            n_fail++;
            $display("FAIL timeout_rerise k=%0d got %b want %b", k, Timeout, et);
         end
      end
      // Accepted strobe clears the flag one cycle later and it stays low.
      Edge = 1'b1; push_pulse(); exp_cnt++;
      for (int c = 0; c < 10; c++) begin
         @(negedge Clock);
         Edge = 1'b0;
         if (sbq.size() > 0) e = sbq.pop_front(); else e = '0;
         n_tests++;
         if ({Level, Busy, Timeout} !== {e.lvl, e.bsy, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_clear c=%0d got L%b B%b T%b want L%b B%b T0",
                     c, Level, Busy, Timeout, e.lvl, e.bsy);
         end
      end
   endtask

   task automatic test_disable_reset();
      exp_t e;
      for (int c = 0; c <= 16; c++) begin
         @(negedge Clock);
         if (sbq.size() > 0) e = sbq.pop_front(); else e = '0;
         n_tests++;
         if ({Level, Busy} !== {e.lvl, e.bsy}) begin
            n_fail++;
            $display("FAIL disable_wave c=%0d got L%b B%b want L%b B%b", c, Level, Busy, e.lvl, e.bsy);
         end
         if (c == 10) begin
            n_tests++;
            if (EdgeCount !== exp_cnt || Timeout !== 1'b0) begin
               n_fail++;
               $display("FAIL disable_ignore got cnt=%0d T%b want cnt=%0d T0", EdgeCount, Timeout, exp_cnt);
            end
         end
         DigitSupply = (c >= 2 && c < 10) ? 2'b11 : 2'b10;
         Edge        = (c == 0) || (c == 4) || (c == 6) || (c == 14);
         if (c == 0 || c == 14) begin push_pulse(); exp_cnt++; end
         if (c == 2) sbq.delete();
      end
      // Mid-HIGH asynchronous reset: outputs clear without waiting for a clock.
      Edge = 1'b0;
      #2 nReset = 1'b0;
      #1;
      n_tests++;
      if ({Level, Busy, Overrun, Timeout} !== 4'b0000 || EdgeCount !== '0) begin
         n_fail++;
         $display("FAIL async_reset got L%b B%b O%b T%b cnt=%0d want all 0",
                  Level, Busy, Overrun, Timeout, EdgeCount);
      end
      sbq.delete(); exp_cnt = '0;
      @(negedge Clock);
      nReset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
`ifndef EDGE_TO_LEVEL_RETRIGGER_EN
      test_overrun();
`else
      test_retrigger();
`endif
      test_back_to_back();
      test_timeout();
      test_disable_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/edge_to_level.md
Name: edge_to_level

Overview:
Converts single-cycle Edge strobes back into a regenerated level waveform, for a block that needs a clean high phase rather than an edge pulse. Each accepted strobe produces a high phase of fixed length followed by a guard low phase. The block counts accepted edges, flags overruns, and flags loss of edges via a timeout. It operates only while the DigitSupply rail pair is valid.

Parameters:
HIGH_CYCLES, 4, Level high-phase length in Clock cycles (>=1)
GAP_CYCLES, 2, mandatory low guard after each high phase (>=0)
TIMEOUT_CYCLES, 64, idle cycles without an accepted edge before Timeout asserts (>=2)
CNT_W, 8, EdgeCount width

Ports:
Clock  input  1  single system clock, rising-edge active
nReset  input  1  asynchronous active-low reset
DigitSupply  input  2  rail pair; block enabled only when equal to 2'b10
Edge  input  1  single-cycle edge strobe, synchronous to Clock
ClearOverrun  input  1  synchronous clear of Overrun
Level  output  1  regenerated level, registered
Busy  output  1  high in HIGH or GAP state
Overrun  output  1  sticky flag: an edge was dropped
Timeout  output  1  level flag: no accepted edge for TIMEOUT_CYCLES
EdgeCount  output  CNT_W  count of accepted edges, wraps modulo 2^CNT_W

Behaviour:
- Reset, asynchronous and active-low: state IDLE. Level=0, Busy=0, Overrun=0, Timeout=0, EdgeCount=0, all internal counters 0.
- Enabled means DigitSupply==2'b10. While not enabled:
  - State is forced to IDLE next cycle; Level=0, Busy=0.
  - Edge is ignored: not counted, does not set Overrun.
  - Timeout counter is held at 0 and Timeout is cleared.
  - ClearOverrun still works.
- FSM states: IDLE, HIGH, GAP.
- IDLE:
  - Edge=1 accepts the edge. Next cycle: state HIGH, Level=1, EdgeCount+1, Timeout cleared. Latency is 1 cycle from Edge to Level.
- HIGH:
  - Level stays 1 for exactly HIGH_CYCLES cycles.
  - Then GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - Level=0 for exactly GAP_CYCLES cycles, then IDLE.
- Edge in HIGH or GAP, including the last cycle of either, is dropped. The drop sets Overrun the next cycle and does not increment EdgeCount.
- An edge on the first IDLE cycle after GAP is accepted. Back-to-back period is therefore HIGH_CYCLES+GAP_CYCLES+1 cycles minimum.
- Overrun clears only on ClearOverrun. If a set and ClearOverrun occur in the same cycle, set wins.
- Timeout counter:
  - Increments each enabled IDLE cycle with no Edge, and saturates at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES asserts Timeout on the following cycle.
  - Resets to 0 on an accepted edge.
  - Holds its value during HIGH and GAP.
- EdgeCount wraps from 2^CNT_W-1 to 0 with no flag.
- Disable mid-phase: Level drops the next cycle. Nothing resumes on re-enable; the block waits in IDLE.
- Reset mid-phase: immediate return to reset values, no glitch beyond the asynchronous clear.

Optional Feature:
Macro EDGE_TO_LEVEL_RETRIGGER_EN.
- Defined:
  - Edge in HIGH is accepted. The HIGH counter restarts, so Level stays high for HIGH_CYCLES more cycles, and EdgeCount increments.
  - Edge in GAP is accepted: the block returns to HIGH next cycle.
  - Overrun never sets and reads 0. The port remains present.
- Undefined: drop and Overrun behaviour as above.

Test Plan:
- Reset, then DigitSupply=2'b10 and one Edge at cycle 10 (defaults) -> Level=1 cycles 11-14, Busy=1 cycles 11-16, EdgeCount=1, Overrun=0.
- Edge at cycles 10 and 13 (defaults) -> second edge dropped, Overrun=1 from cycle 14, EdgeCount=1. Then ClearOverrun and an edge coinciding in one cycle -> Overrun remains 1.
- Edges every 7 cycles (period HIGH+GAP+1) x300, CNT_W=8 -> every edge accepted, no Overrun, EdgeCount wraps to 44.
- No edges for 64 enabled idle cycles -> Timeout=1 on cycle 65. Next edge -> Timeout=0 one cycle later.
- DigitSupply=2'b11 during HIGH -> Level=0 next cycle, subsequent Edges ignored (EdgeCount unchanged). nReset pulse mid-HIGH -> all outputs 0 immediately.
- With EDGE_TO_LEVEL_RETRIGGER_EN, edges at cycles 10 and 12 -> Level high cycles 11-16, EdgeCount=2, Overrun=0.
